vending_machine: RTL and testbench
==================================

Name: vending_machine

Overview:
- Single-product vending machine control FSM; product price fixed at 3 rupees.
- Accepts one coin code per clock cycle: 1-rupee or 2-rupee coin, or no coin.
- Issues a one-cycle product-dispense pulse once credit reaches the price.
- Issues a one-cycle change pulse (1 rupee) when credit overshoots the price.
- Sits between the coin-acceptor decoder and the dispense/refund actuators.

Parameters:
- None. Price (3), coin values (1, 2) and change value (1) are fixed.

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- coin  input  2  coin code sampled every rising edge: 00 = no coin, 01 = no coin, 10 = 1 rupee, 11 = 2 rupees
- prod  output  1  dispense pulse, registered, high for exactly one cycle per sale
- change  output  1  1-rupee refund pulse, registered, high together with prod when overpaid

Interface note (already decided): one clock (clk); reset (rst) is synchronous and active-high.

Behaviour:
- States encode accumulated credit:
  - S0 = 0 rupees
  - S1 = 1 rupee
  - S2 = 2 rupees
  - State register 2 bits; encoding 11 is unused.
- Coin value v: 00/01 -> 0; 10 -> 1; 11 -> 2.
- Sampling rule: coin is sampled on every rising edge. A code held for N cycles counts as N coins; no edge detection is performed.
- Next-state and output computation, with sum = credit + v:
  - sum < 3: next credit = sum; prod = 0, change = 0.
  - sum == 3: next state S0; prod = 1, change = 0.
  - sum == 4 (only S2 + 2-rupee coin): next state S0; prod = 1, change = 1.
- Output timing:
  - prod and change are registers, updated on the same edge as the state.
  - They are visible in the cycle after the coin is sampled and deassert the following edge unless another sale completes.
  - Back-to-back sales on consecutive cycles are allowed.
- Reset:
  - When rst = 1 at a rising edge: state -> S0, prod -> 0, change -> 0.
  - The coin sampled at that edge is discarded; reset has priority over coin.
  - Reset mid-accumulation discards stored credit with no refund.
  - No asynchronous behaviour; before the first reset edge, state and outputs are undefined.
- Illegal state (11) recovers to S0 on the next edge with prod = 0, change = 0.
- change is never high without prod.
- No-coin codes (00, 01) hold state and drive outputs low.

Test Plan:
- Reset, then 1-rupee (10) followed by 2-rupee (11) -> after the second edge: prod = 1, change = 0 for one cycle; state S0.
- From S0: 2-rupee, 2-rupee (11,11) -> second coin gives sum 4: prod = 1 and change = 1 for one cycle; state S0.
- Interleaved no-coin codes: 10, 01, 00, 10, 01, 10 -> credit holds across 01/00 cycles; prod pulses only after the third 1-rupee coin; change = 0.
- Full sequence from reset at one coin per cycle: 10,11,01,11,11,01,10,11,00,10,11,11,11,00.
  - prod pulses after coins #2, #5, #8, #11 and #13.
  - change pulses only after #5 and #13.
  - All other cycles: prod = change = 0.
- Reset mid-operation: 11 (credit 2), then rst = 1 with coin = 10 -> state S0, outputs 0, coin ignored; next 10 -> credit 1, no prod.
- Held coin: coin = 10 held for 3 cycles -> prod = 1 on the third cycle's output, then 0; a 4th held cycle leaves credit 1.

Source files
------------

// File: rtl/vending_machine.sv
// Single-product vending controller: price 3, accepts 1- and 2-rupee coins,
// pulses prod on a sale and change alongside it when 4 rupees were inserted.
module vending_machine (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] coin,
  output logic       prod,
  output logic       change
);

  typedef enum logic [1:0] {
    S0 = 2'b00,
    S1 = 2'b01,
    S2 = 2'b10
  } state_t;

  state_t     r_state;
  state_t     w_next;
  logic       r_prod;
  logic       r_change;
  logic       w_prod;
  logic       w_change;
  logic [2:0] w_val;
  logic [2:0] w_credit;
  logic [2:0] w_sum;

  // Codes 00 and 01 both mean "no coin"; only bit 1 marks a real coin.
  always_comb begin
    w_val = 3'd0;
    if (coin[1]) w_val = coin[0] ? 3'd2 : 3'd1;
  end

  always_comb begin
    w_next   = S0;
    w_prod   = 1'b0;
    w_change = 1'b0;
    w_credit = 3'd0;
    w_sum    = 3'd0;
    case (r_state)
      S0, S1, S2: begin
        w_credit = {1'b0, r_state};
        w_sum    = w_credit + w_val;
        case (w_sum)
          3'd0:    w_next = S0;
          3'd1:    w_next = S1;
          3'd2:    w_next = S2;
          3'd3:    w_prod = 1'b1;
          3'd4: begin
            w_prod   = 1'b1;
            w_change = 1'b1;
          end
          default: w_next = S0;
        endcase
      end
      // Encoding 11 drops back to empty credit with no outputs.
      default: w_next = S0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S0;
      r_prod   <= 1'b0;
      r_change <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_prod   <= w_prod;
      r_change <= w_change;
    end
  end

  assign prod   = r_prod;
  assign change = r_change;

endmodule

// File: tb/tb_vending_machine.sv
// Directed bench for vending_machine: each task drives coins and checks
// the registered prod/change pair one cycle after every sampling edge.
module tb_vending_machine;

  logic       clk;
  logic       rst;
  logic [1:0] coin;
  logic       prod;
  logic       change;

  int errors = 0;
  int checks = 0;

  vending_machine dut (
    .clk    (clk),
    .rst    (rst),
    .coin   (coin),
    .prod   (prod),
    .change (change)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present one coin code for one edge; outputs are sampled 1 ns later.
  task automatic apply(input logic [1:0] c, input logic r);
    coin = c;
    rst  = r;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    apply(2'b11, 1'b1);
    apply(2'b11, 1'b1);
    checks++;
    if ({prod, change} !== 2'b00) begin
      errors++;
      $display("FAIL reset_outputs got=%b%b want=00", prod, change);
    end
    // From S0 three 1-rupee coins are needed; a leftover credit would sell early.
    apply(2'b10, 1'b0);
    apply(2'b10, 1'b0);
    checks++;
    if ({prod, change} !== 2'b00) begin
      errors++;
      $display("FAIL reset_credit_zero got=%b%b want=00", prod, change);
    end
    apply(2'b10, 1'b0);
    checks++;
    if ({prod, change} !== 2'b10) begin
      errors++;
      $display("FAIL reset_then_three_ones got=%b%b want=10", prod, change);
    end
  endtask

  task automatic test_exact_price();
    apply(2'b10, 1'b0);
    checks++;
    if ({prod, change} !== 2'b00) begin
      errors++;
      $display("FAIL exact_first got=%b%b want=00", prod, change);
    end
    apply(2'b11, 1'b0);
    checks++;
    if ({prod, change} !== 2'b10) begin
      errors++;
      $display("FAIL exact_sale got=%b%b want=10", prod, change);
    end
    apply(2'b00, 1'b0);
    checks++;
    if ({prod, change} !== 2'b00) begin
      errors++;
      $display("FAIL exact_pulse_drop got=%b%b want=00", prod, change);
    end
  endtask

  task automatic test_overpay();
    apply(2'b11, 1'b0);
    checks++;
    if ({prod, change} !== 2'b00) begin
      errors++;
      $display("FAIL overpay_first got=%b%b want=00", prod, change);
    end
    apply(2'b11, 1'b0);
    checks++;
    if ({prod, change} !== 2'b11) begin
      errors++;
      $display("FAIL overpay_sale got=%b%b want=11", prod, change);
    end
    apply(2'b01, 1'b0);
    checks++;
    if ({prod, change} !== 2'b00) begin
      errors++;
      $display("FAIL overpay_pulse_drop got=%b%b want=00", prod, change);
    end
  endtask

  task automatic test_no_coin_hold();
    logic [1:0] seq [6] = '{2'b10, 2'b01, 2'b00, 2'b10, 2'b01, 2'b10};
    logic [1:0] exp [6] = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b10};
    for (int i = 0; i < 6; i++) begin
      apply(seq[i], 1'b0);
      checks++;
      if ({prod, change} !== exp[i]) begin
        errors++;
        $display("FAIL nocoin_step%0d got=%b%b want=%b", i, prod, change, exp[i]);
      end
    end
  endtask

  task automatic test_full_sequence();
    logic [1:0] seq [14] = '{2'b10, 2'b11, 2'b01, 2'b11, 2'b11, 2'b01, 2'b10,
                             2'b11, 2'b00, 2'b10, 2'b11, 2'b11, 2'b11, 2'b00};
    logic [1:0] exp [14] = '{2'b00, 2'b10, 2'b00, 2'b00, 2'b11, 2'b00, 2'b00,
                             2'b10, 2'b00, 2'b00, 2'b10, 2'b00, 2'b11, 2'b00};
    apply(2'b00, 1'b1);
    for (int i = 0; i < 14; i++) begin
      apply(seq[i], 1'b0);
      checks++;
      if ({prod, change} !== exp[i]) begin
        errors++;
        $display("FAIL full_coin%0d got=%b%b want=%b", i + 1, prod, change, exp[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    apply(2'b11, 1'b0);
    apply(2'b10, 1'b1);
    checks++;
    if ({prod, change} !== 2'b00) begin
      errors++;
      $display("FAIL midreset_out got=%b%b want=00", prod, change);
    end
    apply(2'b10, 1'b0);
    checks++;
    if ({prod, change} !== 2'b00) begin
      errors++;
      $display("FAIL midreset_credit1 got=%b%b want=00", prod, change);
    end
    apply(2'b11, 1'b0);
    checks++;
    if ({prod, change} !== 2'b10) begin
      errors++;
      $display("FAIL midreset_sale got=%b%b want=10", prod, change);
    end
    // Reset has priority even when the coin would complete a sale with change.
    apply(2'b11, 1'b0);
    apply(2'b11, 1'b1);
    checks++;
    if ({prod, change} !== 2'b00) begin
      errors++;
      $display("FAIL reset_over_sale got=%b%b want=00", prod, change);
    end
  endtask

  task automatic test_held_coin();
    logic [1:0] exp [4] = '{2'b00, 2'b00, 2'b10, 2'b00};
    for (int i = 0; i < 4; i++) begin
      apply(2'b10, 1'b0);
      checks++;
      if ({prod, change} !== exp[i]) begin
        errors++;
        $display("FAIL held_cycle%0d got=%b%b want=%b", i + 1, prod, change, exp[i]);
      end
    end
    // Credit is 1 now: a 2-rupee coin completes the sale exactly.
    apply(2'b11, 1'b0);
    checks++;
    if ({prod, change} !== 2'b10) begin
      errors++;
      $display("FAIL held_leftover got=%b%b want=10", prod, change);
    end
  endtask

  initial begin
    rst  = 1'b1;
    coin = 2'b00;
    test_reset();
    test_exact_price();
    test_overpay();
    test_no_coin_hold();
    test_full_sequence();
    test_reset_mid();
    apply(2'b00, 1'b1);
    test_held_coin();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
